spi_program_loader: RTL

SPI_PROGRAM_LOADER -- requirements
Module: spi_program_loader

---
 rtl/spi_program_loader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_program_loader.sv
// spi_program_loader
//   Receives a program over a slave SPI link (mode 0, MSB first) into a small
//   word memory. On request it replays that program to an execution unit at
//   one instruction per clock.
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   reset      asynchronous, active-high
//   sclk       SPI clock (asynchronous to clk)
//   cs_n       SPI chip select, active low (asynchronous)
//   mosi       SPI data in (asynchronous)
//   miso       SPI status out: {overflow, 0, prog_len}, MSB first
//   run        level request to execute the stored program
//   opcode     instruction opcode (0 = no-op whenever start is low)
//   operand    instruction operand
//   start      high in the cycles that opcode/operand carry an instruction
//   pc         index of the next instruction to issue
//   prog_len   number of stored words
//   overflow   sticky: a complete word was dropped because memory was full
//   busy       high while running or holding in DONE
module spi_program_loader #(
  parameter int ROM_ADDRESS_WIDTH = 5,
  parameter int INPUT_DATA_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sclk,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  input  logic                          run,
  output logic [INPUT_DATA_WIDTH-1:0]   opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0] operand,
  output logic                          start,
  output logic [ROM_ADDRESS_WIDTH:0]    pc,
  output logic [ROM_ADDRESS_WIDTH:0]    prog_len,
  output logic                          overflow,
  output logic                          busy
);

  localparam int AW     = ROM_ADDRESS_WIDTH;
  localparam int IW     = INPUT_DATA_WIDTH;
  localparam int WORD_W = 3 * IW;
  localparam int DEPTH  = 1 << AW;
  localparam int BC_W   = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [AW:0]     FULL     = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  // Synchronizers; the third sclk/cs_n flop holds the previous level for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t              state_q, state_d;
  logic [AW:0]         pc_q, pc_d;
  logic [AW:0]         prog_len_q, prog_len_d;
  logic                overflow_q, overflow_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic [IW-1:0]       opcode_q, opcode_d;
  logic [2*IW-1:0]     operand_q, operand_d;
  logic                miso_q, miso_d;
  logic [7:0]          miso_sh_q, miso_sh_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [WORD_W-1:0]   mem_wdata;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, spi_en;
  logic [7:0] status;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;
  // Loading is locked out while a program executes so the memory stays stable.
  assign spi_en    = (state_q == S_IDLE) || (state_q == S_LOAD);
  // Captured at cs_n fall, before that same edge clears the counters.
  assign status    = 8'({overflow_q, 1'b0, prog_len_q});
  assign mem_waddr = prog_len_q[AW-1:0];
  assign mem_wdata = {shift_q[WORD_W-2:0], mosi_s2_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    overflow_d = overflow_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    miso_sh_d  = miso_sh_q;
    start_d    = 1'b0;
    opcode_d   = '0;
    operand_d  = '0;
    mem_we     = 1'b0;

    // SPI receive: every cs_n fall starts a fresh program, cs_n rise drops a partial word.
    if (spi_en) begin
      if (cs_fall) begin
        prog_len_d = '0;
        overflow_d = 1'b0;
        bit_cnt_d  = '0;
      end else if (cs_rise) begin
        bit_cnt_d = '0;
      end else if (!cs_s2_q && sclk_rise) begin
        shift_d = mem_wdata;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (prog_len_q == FULL) begin
            overflow_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    // SPI status transmit: bit 7 is presented before the first sclk rise.
    if (cs_fall) begin
      miso_sh_d = status;
    end else if (cs_s2_q) begin
      miso_sh_d = '0;
    end else if (sclk_fall) begin
      miso_sh_d = {miso_sh_q[6:0], 1'b0};
    end
    miso_d = ~cs_s2_q & miso_sh_d[7];

    case (state_q)
      S_IDLE: begin
        if (!cs_s2_q) begin
          state_d = S_LOAD;
        end else if (run && (prog_len_q != '0)) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_LOAD: begin
        if (cs_s2_q) state_d = S_IDLE;
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end else begin
          start_d                = 1'b1;
          {opcode_d, operand_d}  = mem_q[pc_q[AW-1:0]];
          pc_d                   = pc_q + 1'b1;
          if (pc_q == prog_len_q - 1'b1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_s3_q    <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= S_IDLE;
      pc_q       <= '0;
      prog_len_q <= '0;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      miso_q     <= 1'b0;
      miso_sh_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      sclk_s1_q  <= sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      cs_s1_q    <= cs_n;
      cs_s2_q    <= cs_s1_q;
      cs_s3_q    <= cs_s2_q;
      mosi_s1_q  <= mosi;
      mosi_s2_q  <= mosi_s1_q;
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      overflow_q <= overflow_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      miso_q     <= miso_d;
      miso_sh_q  <= miso_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Program memory has no reset; it is only ever written by SPI load.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign miso     = miso_q;
  assign opcode   = opcode_q;
  assign operand  = operand_q;
  assign start    = start_q;
  assign pc       = pc_q;
  assign prog_len = prog_len_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule
